// File: rtl/sv_pixel_streamer.sv
// sv_pixel_streamer: producer side of the hwf kernel pixel interface.
// Fetches the test vector and each support vector from sync-read memories and
// streams matching pixel pairs plus the per-SV coefficient Bi to the kernel.
// Optional feature: define SV_ZERO_SKIP_EN to skip SVs whose coefficient is zero.
module sv_pixel_streamer #(
  parameter int unsigned XLEN_PIXEL    = 8,
  parameter int unsigned NUM_OF_PIXELS = 10,
  parameter int unsigned NUM_OF_SV     = 87,
  parameter int unsigned SV_ADDR_W     = 10,
  parameter int unsigned SV_IDX_W      = 7,
  parameter int unsigned PIX_IDX_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      kernel_done,
  output logic [SV_ADDR_W-1:0]      sv_addr,
  input  logic [XLEN_PIXEL-1:0]     sv_rdata,
  output logic [PIX_IDX_W-1:0]      test_addr,
  input  logic [XLEN_PIXEL-1:0]     test_rdata,
  output logic [SV_IDX_W-1:0]       bi_addr,
  input  logic [2*XLEN_PIXEL-1:0]   bi_rdata,
  output logic [XLEN_PIXEL-1:0]     x_test,
  output logic [XLEN_PIXEL-1:0]     x_sv,
  output logic [2*XLEN_PIXEL-1:0]   Bi,
  output logic                      stall_MEM,
  output logic                      sv_last,
  output logic [SV_IDX_W-1:0]       sv_index,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned BI_W = 2 * XLEN_PIXEL;
  localparam logic [PIX_IDX_W-1:0] LAST_PIX = PIX_IDX_W'(NUM_OF_PIXELS - 1);
  localparam logic [SV_IDX_W-1:0]  LAST_SV  = SV_IDX_W'(NUM_OF_SV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT_K = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PIX_IDX_W-1:0]   pix;
  logic                   skip_c;
  logic                   last_sv_c;
  logic [SV_ADDR_W-1:0]   next_base_c;

  // Memory read data goes straight to the kernel; it is only meaningful while stall_MEM is low.
  assign x_test = test_rdata;
  assign x_sv   = sv_rdata;

  assign last_sv_c   = (sv_index == LAST_SV);
  assign next_base_c = SV_ADDR_W'((32'(sv_index) + 32'd1) * NUM_OF_PIXELS);

`ifdef SV_ZERO_SKIP_EN
  // A zero coefficient seen in the first stream cycle drops the whole SV.
  assign skip_c = (state == S_STREAM) && (pix == '0) && (bi_rdata == '0);
`else
  assign skip_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_STREAM;
      S_STREAM: begin
        if (skip_c)               state_nxt = last_sv_c ? S_DONE : S_FETCH;
        else if (pix == LAST_PIX) state_nxt = S_WAIT_K;
      end
      S_WAIT_K: if (kernel_done) state_nxt = last_sv_c ? S_DONE : S_FETCH;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    stall_MEM = 1'b1;
    sv_last   = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    if (state == S_STREAM && !skip_c) begin
      stall_MEM = 1'b0;
      sv_last   = (pix == LAST_PIX);
    end
  end

  // Index counters, prefetch addresses and the coefficient register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_index  <= '0;
      pix       <= '0;
      sv_addr   <= '0;
      test_addr <= '0;
      bi_addr   <= '0;
      Bi        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sv_index  <= '0;
            pix       <= '0;
            sv_addr   <= '0;
            test_addr <= '0;
            bi_addr   <= '0;
          end
        end
        S_FETCH: begin
          pix <= '0;
          // Pixel 0 was addressed this cycle; move on to pixel 1 if there is one.
          if (test_addr != LAST_PIX) begin
            sv_addr   <= sv_addr + SV_ADDR_W'(1);
            test_addr <= test_addr + PIX_IDX_W'(1);
          end
        end
        S_STREAM: begin
          if (skip_c) begin
            if (!last_sv_c) begin
              sv_index  <= sv_index + SV_IDX_W'(1);
              sv_addr   <= next_base_c;
              test_addr <= '0;
              bi_addr   <= sv_index + SV_IDX_W'(1);
            end
          end else begin
            if (pix == '0)       Bi  <= BI_W'(bi_rdata);
            if (pix != LAST_PIX) pix <= pix + PIX_IDX_W'(1);
            // Prefetch stops at the last pixel so addresses never run past the SV.
            if (test_addr != LAST_PIX) begin
              sv_addr   <= sv_addr + SV_ADDR_W'(1);
              test_addr <= test_addr + PIX_IDX_W'(1);
            end
          end
        end
        S_WAIT_K: begin
          if (kernel_done && !last_sv_c) begin
            sv_index  <= sv_index + SV_IDX_W'(1);
            sv_addr   <= next_base_c;
            test_addr <= '0;
            bi_addr   <= sv_index + SV_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sv_pixel_streamer.sv
// Directed bench for sv_pixel_streamer: table of whole-pass scenarios plus
// hand-written reset and coefficient-skip sequences.
module tb_sv_pixel_streamer;

  localparam int unsigned XL  = 8;
  localparam int unsigned NP  = 10;
  // Four SVs so a pass can be reset while streaming SV 3.
  localparam int unsigned NSV = 4;
  localparam int unsigned AW  = 10;
  localparam int unsigned IW  = 7;
  localparam int unsigned PW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            kernel_done;
  logic [AW-1:0]   sv_addr;
  logic [XL-1:0]   sv_rdata;
  logic [PW-1:0]   test_addr;
  logic [XL-1:0]   test_rdata;
  logic [IW-1:0]   bi_addr;
  logic [2*XL-1:0] bi_rdata;
  logic [XL-1:0]   x_test;
  logic [XL-1:0]   x_sv;
  logic [2*XL-1:0] Bi;
  logic            stall_MEM;
  logic            sv_last;
  logic [IW-1:0]   sv_index;
  logic            busy;
  logic            done;

  logic [XL-1:0]   sv_mem   [0:1023];
  logic [XL-1:0]   test_mem [0:15];
  logic [2*XL-1:0] bi_mem   [0:127];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int kd_delay;   // cycles from sv_last to the kernel_done pulse
    bit noise;      // stray kernel_done/start pulses that must be ignored
    int exp_pairs;  // valid pixel pairs expected in the pass
    int exp_done;   // cycle (start = cycle 0) in which done must be high
    int rst_cyc;    // cycle at which reset is forced, 0 = none
  } vec_t;

  vec_t vecs [6];

  sv_pixel_streamer #(
    .XLEN_PIXEL(XL), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV),
    .SV_ADDR_W(AW), .SV_IDX_W(IW), .PIX_IDX_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .kernel_done(kernel_done),
    .sv_addr(sv_addr), .sv_rdata(sv_rdata),
    .test_addr(test_addr), .test_rdata(test_rdata),
    .bi_addr(bi_addr), .bi_rdata(bi_rdata),
    .x_test(x_test), .x_sv(x_sv), .Bi(Bi),
    .stall_MEM(stall_MEM), .sv_last(sv_last), .sv_index(sv_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sync-read memory models, one cycle of latency.
  always @(posedge clk) begin
    sv_rdata   <= sv_mem[sv_addr];
    test_rdata <= test_mem[test_addr];
    bi_rdata   <= bi_mem[bi_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_sv(input int s);
    int r;
    r = s;
`ifdef SV_ZERO_SKIP_EN
    while (r < int'(NSV) && bi_mem[r] == '0) r++;
`endif
    return r;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stall"},    32'(stall_MEM), 32'd1);
    chk({tag, "_Bi"},       32'(Bi),        32'd0);
    chk({tag, "_busy"},     32'(busy),      32'd0);
    chk({tag, "_done"},     32'(done),      32'd0);
    chk({tag, "_sv_last"},  32'(sv_last),   32'd0);
    chk({tag, "_sv_index"}, 32'(sv_index),  32'd0);
    chk({tag, "_sv_addr"},  32'(sv_addr),   32'd0);
    chk({tag, "_test_addr"},32'(test_addr), 32'd0);
    chk({tag, "_bi_addr"},  32'(bi_addr),   32'd0);
  endtask

  task automatic run_pass(input vec_t v);
    int pairs, pix_i, cur_sv, last_c, end_c;
    bit waiting, pred_last, real_kd;
    pairs = 0; pix_i = 0; last_c = -1000; waiting = 0; pred_last = 0;
    cur_sv = next_sv(0);
    end_c = v.exp_done + 2;
    @(posedge clk); #1 start = 1'b1; kernel_done = 1'b0;
    @(negedge clk);
    chk("busy_c0", 32'(busy), 32'd0);
    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk); #1;
      start = v.noise && (c == 7);
      real_kd = waiting && (c == last_c + v.kd_delay);
      kernel_done = real_kd || (v.noise && (c == 5 || pred_last));
      @(negedge clk);
      chk("busy", 32'(busy), 32'((c <= v.exp_done) && (v.rst_cyc == 0 || c <= v.rst_cyc)));
      chk("done", 32'(done), 32'(c == v.exp_done));
      pred_last = 1'b0;
      if (!stall_MEM) begin
        chk("pair_in_wait", 32'(waiting), 32'd0);
        chk("x_sv",     32'(x_sv),     32'(cur_sv * NP + pix_i));
        chk("x_test",   32'(x_test),   32'(test_mem[pix_i]));
        chk("sv_index", 32'(sv_index), 32'(cur_sv));
        chk("sv_last",  32'(sv_last),  32'(pix_i == NP - 1));
        if (pix_i > 0) chk("Bi_stream", 32'(Bi), 32'(bi_mem[cur_sv]));
        pairs++;
        pred_last = (pix_i == NP - 2);
        if (pix_i == NP - 1) begin
          waiting = 1'b1; last_c = c; pix_i = 0;
        end else begin
          pix_i++;
        end
      end else begin
        chk("sv_last_stall", 32'(sv_last), 32'd0);
        if (waiting) begin
          chk("wait_sv_index",  32'(sv_index),  32'(cur_sv));
          chk("wait_sv_addr",   32'(sv_addr),   32'(cur_sv * NP + NP - 1));
          chk("wait_test_addr", 32'(test_addr), 32'(NP - 1));
          chk("wait_bi_addr",   32'(bi_addr),   32'(cur_sv));
          chk("wait_Bi",        32'(Bi),        32'(bi_mem[cur_sv]));
          if (real_kd) begin
            waiting = 1'b0;
            cur_sv = next_sv(cur_sv + 1);
          end
        end
      end
      if (v.rst_cyc != 0 && c == v.rst_cyc) begin
        #1 rst = 1'b1;
        #1 chk_reset_state("midrst");
        @(posedge clk); #1 rst = 1'b0; kernel_done = 1'b0; start = 1'b0;
        break;
      end
    end
    start = 1'b0; kernel_done = 1'b0;
    chk("pairs", 32'(pairs), 32'(v.exp_pairs));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    vec_t skip_v;
    for (int a = 0; a < 1024; a++) sv_mem[a] = XL'(a);
    for (int a = 0; a < 16; a++)   test_mem[a] = XL'(8'hA0 + a);
    for (int a = 0; a < 128; a++)  bi_mem[a] = 16'hFFFF;
    bi_mem[0] = 16'h0100; bi_mem[1] = 16'h0080;
    bi_mem[2] = 16'h0033; bi_mem[3] = 16'h1234;

    //          kd  noise pairs done rst
    vecs[0] = '{4,  1'b0, 40,  61,  0};
    vecs[1] = '{1,  1'b0, 36,  999, 43};   // reset while SV 3 shows pixel 5
    vecs[2] = '{1,  1'b0, 40,  49,  0};
    vecs[3] = '{4,  1'b1, 40,  61,  0};
    vecs[4] = '{50, 1'b0, 40,  245, 0};
    vecs[5] = '{2,  1'b1, 40,  53,  0};

    rst = 1'b1; start = 1'b0; kernel_done = 1'b0;
    #1 chk_reset_state("reset");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("post_reset");

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

`ifdef SV_ZERO_SKIP_EN
    bi_mem[0] = 16'd5; bi_mem[1] = 16'd0; bi_mem[2] = 16'd7; bi_mem[3] = 16'd9;
    skip_v = '{4, 1'b0, 30, 48, 0};
    run_pass(skip_v);
`else
    skip_v = '{4, 1'b0, 40, 61, 0};
    run_pass(skip_v);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
